mem_access_unit: RTL and testbench

MEM-stage memory access controller for the 5-stage pipeline. It consumes the outputs of the EXE/MEM pipeline register, runs a variable-latency req/ack transaction to the data memory for loads and stores, and freezes the upstream pipeline with `stall` while an access is outstanding. It also contains the MEM/WB pipeline register: its `wb_*` outputs feed the write-back stage directly.

---
 rtl/mem_access_unit.sv | 209 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage memory access controller with the MEM/WB pipeline register.
// Loads and stores run a req/ack handshake to data memory. While an access is
// outstanding, the upstream pipeline is frozen through `stall`. A misaligned
// access is suppressed and flagged. An access that sees no ack within
// MAX_WAIT request cycles is aborted and flagged.
//
// Parameters
//   MAX_WAIT    request cycles allowed without ack before abort (1..255)
//
// Ports
//   clk, clrn                 clock, asynchronous active-low reset
//   mem_wreg/m2reg/wmem       control bits from EXE/MEM
//   mem_alu, mem_b, mem_rn    address / store data / destination register
//   dmem_req/we/addr/wdata    registered data-memory request
//   dmem_ack, dmem_rdata      memory completion and read data
//   stall                     combinational freeze of PC..EXE/MEM registers
//   wb_wreg/m2reg/rn/alu/mdo  MEM/WB register outputs
//   align_err, bus_err        one-cycle error pulses
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        mem_wreg,
    input  logic        mem_m2reg,
    input  logic        mem_wmem,
    input  logic [31:0] mem_alu,
    input  logic [31:0] mem_b,
    input  logic [4:0]  mem_rn,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        wb_wreg,
    output logic        wb_m2reg,
    output logic [4:0]  wb_rn,
    output logic [31:0] wb_alu,
    output logic [31:0] wb_mdo,
    output logic        align_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wb_wreg_q, wb_wreg_d;
    logic        wb_m2reg_q, wb_m2reg_d;
    logic [4:0]  wb_rn_q, wb_rn_d;
    logic [31:0] wb_alu_q, wb_alu_d;
    logic [31:0] wb_mdo_q, wb_mdo_d;
    logic        align_q, align_d;
    logic        bus_q, bus_d;
    logic        stall_c;

    logic acc, mis, start, timeout;

    assign acc     = mem_m2reg | mem_wmem;
    assign mis     = (mem_alu[1:0] != 2'b00);
    assign start   = acc & ~mis;
    assign timeout = (cnt_q == CNT_LAST);

    // State and datapath registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wb_wreg_q  <= 1'b0;
            wb_m2reg_q <= 1'b0;
            wb_rn_q    <= '0;
            wb_alu_q   <= '0;
            wb_mdo_q   <= '0;
            align_q    <= 1'b0;
            bus_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wb_wreg_q  <= wb_wreg_d;
            wb_m2reg_q <= wb_m2reg_d;
            wb_rn_q    <= wb_rn_d;
            wb_alu_q   <= wb_alu_d;
            wb_mdo_q   <= wb_mdo_d;
            align_q    <= align_d;
            bus_q      <= bus_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BUSY;
            BUSY:    if (dmem_ack || timeout) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        stall_c    = 1'b0;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wb_wreg_d  = wb_wreg_q;
        wb_m2reg_d = wb_m2reg_q;
        wb_rn_d    = wb_rn_q;
        wb_alu_d   = wb_alu_q;
        wb_mdo_d   = wb_mdo_q;
        align_d    = 1'b0;
        bus_d      = 1'b0;

        case (state_q)
            IDLE: begin
                stall_c = start;
                if (start) begin
                    addr_d    = mem_alu;
                    wdata_d   = mem_b;
                    we_d      = mem_wmem;
                    req_d     = 1'b1;
                    cnt_d     = '0;
                    wb_wreg_d = 1'b0;
                end else begin
                    wb_wreg_d  = mem_wreg;
                    wb_m2reg_d = mem_m2reg;
                    wb_rn_d    = mem_rn;
                    wb_alu_d   = mem_alu;
                    wb_mdo_d   = '0;
                    // Misaligned access: let the rest pass, but kill the write-back.
                    if (acc) begin
                        wb_wreg_d  = 1'b0;
                        wb_m2reg_d = 1'b0;
                        align_d    = 1'b1;
                    end
                end
            end

            BUSY: begin
                stall_c = 1'b1;
                // Ack takes priority over a timeout in the same cycle.
                if (dmem_ack) begin
                    wb_wreg_d  = mem_wreg;
                    wb_m2reg_d = mem_m2reg;
                    wb_rn_d    = mem_rn;
                    wb_alu_d   = mem_alu;
                    wb_mdo_d   = mem_m2reg ? dmem_rdata : '0;
                    req_d      = 1'b0;
                end else if (timeout) begin
                    req_d      = 1'b0;
                    wb_wreg_d  = 1'b0;
                    wb_m2reg_d = 1'b0;
                    bus_d      = 1'b1;
                end else begin
                    cnt_d     = cnt_q + 8'd1;
                    wb_wreg_d = 1'b0;
                end
            end

            DONE: begin
                wb_wreg_d  = 1'b0;
                wb_m2reg_d = 1'b0;
            end

            default: ;
        endcase
    end

    // Gating with clrn keeps stall low during reset even if a load sits on the inputs.
    assign stall      = clrn & stall_c;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign wb_wreg    = wb_wreg_q;
    assign wb_m2reg   = wb_m2reg_q;
    assign wb_rn      = wb_rn_q;
    assign wb_alu     = wb_alu_q;
    assign wb_mdo     = wb_mdo_q;
    assign align_err  = align_q;
    assign bus_err    = bus_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Scoreboard bench: the stimulus process pushes the expected events (memory
// request, write-back result, error pulse) into a queue. A negedge monitor
// pops and compares whenever the DUT shows one of these events.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int unsigned MW = 4;

    logic        clk = 1'b0;
    logic        clrn = 1'b1;
    logic        mem_wreg = 1'b0, mem_m2reg = 1'b0, mem_wmem = 1'b0;
    logic [31:0] mem_alu = '0, mem_b = '0;
    logic [4:0]  mem_rn = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        stall, wb_wreg, wb_m2reg;
    logic [4:0]  wb_rn;
    logic [31:0] wb_alu, wb_mdo;
    logic        align_err, bus_err;

    mem_access_unit #(.MAX_WAIT(MW)) dut (
        .clk(clk), .clrn(clrn),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_wmem(mem_wmem),
        .mem_alu(mem_alu), .mem_b(mem_b), .mem_rn(mem_rn),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .wb_wreg(wb_wreg), .wb_m2reg(wb_m2reg), .wb_rn(wb_rn),
        .wb_alu(wb_alu), .wb_mdo(wb_mdo), .align_err(align_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_REQ, EV_WB, EV_ALIGN, EV_BUS} ev_e;
    typedef struct {
        ev_e         kind;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          len;     // expected req length, 0 = not checked
        logic        wreg;
        logic        m2;
        logic [4:0]  rn;
        logic [31:0] alu;
        logic [31:0] mdo;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic push_req(input logic [31:0] a, input logic we, input logic [31:0] d, input int len);
        exp_t e;
        e.kind = EV_REQ; e.addr = a; e.we = we; e.wdata = d; e.len = len;
        e.wreg = 0; e.m2 = 0; e.rn = '0; e.alu = '0; e.mdo = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_wb(input logic wr, input logic m2, input logic [4:0] rn,
                           input logic [31:0] alu, input logic [31:0] mdo);
        exp_t e;
        e.kind = EV_WB; e.addr = '0; e.we = 0; e.wdata = '0; e.len = 0;
        e.wreg = wr; e.m2 = m2; e.rn = rn; e.alu = alu; e.mdo = mdo;
        exp_q.push_back(e);
    endtask

    task automatic push_ev(input ev_e k);
        exp_t e;
        e.kind = k; e.addr = '0; e.we = 0; e.wdata = '0; e.len = 0;
        e.wreg = 0; e.m2 = 0; e.rn = '0; e.alu = '0; e.mdo = '0;
        exp_q.push_back(e);
    endtask

    task automatic pop_exp(input ev_e k, output exp_t e, output bit ok);
        ok = 0;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event_%s: got unexpected event, required none (queue empty) t=%0t", k.name(), $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k) begin
                bad++;
                $display("FAIL event_order: got %s required %s t=%0t", k.name(), e.kind.name(), $time);
            end else begin
                ok = 1;
            end
        end
    endtask

    // ---------------- monitor ----------------
    exp_t cur_req;
    bit   cur_ok = 0;
    bit   in_req = 0;
    int   req_len = 0;

    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (!clrn) begin
            in_req = 0;
            cur_ok = 0;
        end else begin
            if (dmem_req && !in_req) begin
                pop_exp(EV_REQ, cur_req, cur_ok);
                in_req  = 1;
                req_len = 0;
            end
            if (dmem_req) begin
                req_len++;
                if (cur_ok) begin
                    total++;
                    if ({dmem_addr, dmem_we, dmem_wdata} !== {cur_req.addr, cur_req.we, cur_req.wdata}) begin
                        bad++;
                        $display("FAIL req_fields: got addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                                 dmem_addr, dmem_we, dmem_wdata, cur_req.addr, cur_req.we, cur_req.wdata);
                    end
                end
            end
            if (!dmem_req && in_req) begin
                in_req = 0;
                if (cur_ok && cur_req.len != 0) begin
                    total++;
                    if (req_len != cur_req.len) begin
                        bad++;
                        $display("FAIL req_length: got %0d required %0d", req_len, cur_req.len);
                    end
                end
            end
            if (wb_wreg || wb_m2reg) begin
                pop_exp(EV_WB, e, ok);
                if (ok) begin
                    total++;
                    if ({wb_wreg, wb_m2reg, wb_rn, wb_alu, wb_mdo} !== {e.wreg, e.m2, e.rn, e.alu, e.mdo}) begin
                        bad++;
                        $display("FAIL wb_result: got wreg=%b m2reg=%b rn=%0d alu=%h mdo=%h required wreg=%b m2reg=%b rn=%0d alu=%h mdo=%h",
                                 wb_wreg, wb_m2reg, wb_rn, wb_alu, wb_mdo, e.wreg, e.m2, e.rn, e.alu, e.mdo);
                    end
                end
            end
            if (align_err) pop_exp(EV_ALIGN, e, ok);
            if (bus_err)   pop_exp(EV_BUS, e, ok);
        end
    end

    // ---------------- stimulus ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    // Presents one instruction and plays the memory side: ack in the ack_n-th
    // request cycle (0 = never). Returns when the stage accepts the next one.
    task automatic run_op(input string name, input logic wr, input logic m2, input logic wm,
                          input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                          input int ack_n, input logic [31:0] rdata, input int exp_stall);
        int stalls = 0;
        int reqc = 0;
        bit st;
        bit consumed = 0;
        mem_wreg = wr; mem_m2reg = m2; mem_wmem = wm;
        mem_alu = alu; mem_b = b; mem_rn = rn;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0BAD_0BAD;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            st = stall;
            if (st) stalls++;
            @(posedge clk);
            #1;
            if (!st) begin
                consumed = 1;
                break;
            end
            if (dmem_req) begin
                reqc++;
                dmem_ack   = (reqc == ack_n);
                dmem_rdata = (reqc == ack_n) ? rdata : 32'h0BAD_0BAD;
            end else begin
                dmem_ack = 1'b0;
            end
        end
        dmem_ack = 1'b0;
        total++;
        if (!consumed) begin
            bad++;
            $display("FAIL %s_progress: got no completion within 40 cycles, required completion", name);
        end else if (stalls != exp_stall) begin
            bad++;
            $display("FAIL %s_stall_cycles: got %0d required %0d", name, stalls, exp_stall);
        end
    endtask

    initial begin
        // Reset with an aligned load on the inputs: everything, stall included, must be 0.
        #1 clrn = 1'b0;
        mem_m2reg = 1'b1; mem_wreg = 1'b1; mem_alu = 32'h100;
        #2;
        check("reset_outputs",
              {30'b0, dmem_req, dmem_we, dmem_addr},
              64'h0);
        check("reset_wb",
              {wb_wreg, wb_m2reg, wb_rn, wb_alu, wb_mdo[24:0]}, 64'h0);
        check("reset_stall_err", {61'b0, stall, align_err, bus_err}, 64'h0);
        mem_m2reg = 1'b0; mem_wreg = 1'b0; mem_alu = '0;
        @(posedge clk);
        @(posedge clk);
        #1 clrn = 1'b1;

        // ALU op: wb next cycle, no stall
        push_wb(1, 0, 5'd5, 32'h1234, 32'h0);
        run_op("alu", 1, 0, 0, 32'h1234, 32'h0, 5'd5, 0, 32'h0, 0);

        // Load, ack in 3rd req cycle
        push_req(32'h100, 0, 32'h55, 3);
        push_wb(1, 1, 5'd7, 32'h100, 32'hDEADBEEF);
        run_op("load3", 1, 1, 0, 32'h100, 32'h55, 5'd7, 3, 32'hDEADBEEF, 4);

        // Store, ack in 1st req cycle (no write-back event)
        push_req(32'h200, 1, 32'hCAFE, 1);
        run_op("store1", 0, 0, 1, 32'h200, 32'hCAFE, 5'd0, 1, 32'h0, 2);

        // Misaligned load
        push_ev(EV_ALIGN);
        run_op("misaligned_ld", 1, 1, 0, 32'h102, 32'h0, 5'd3, 0, 32'h0, 0);

        // Timeout: req for MAX_WAIT cycles, bus_err
        push_req(32'h104, 0, 32'h0, MW);
        push_ev(EV_BUS);
        run_op("timeout", 1, 1, 0, 32'h104, 32'h0, 5'd4, 0, 32'h0, 1 + MW);

        // Ack in the last allowed cycle wins
        push_req(32'h108, 0, 32'h0, MW);
        push_wb(1, 1, 5'd8, 32'h108, 32'h11223344);
        run_op("ack_last", 1, 1, 0, 32'h108, 32'h0, 5'd8, MW, 32'h11223344, 1 + MW);

        // Back-to-back load, then ALU ops with zero added cycles
        push_req(32'h10C, 0, 32'h77, 2);
        push_wb(1, 1, 5'd10, 32'h10C, 32'hA5A5A5A5);
        run_op("load_b2b", 1, 1, 0, 32'h10C, 32'h77, 5'd10, 2, 32'hA5A5A5A5, 3);
        push_wb(1, 0, 5'd9, 32'hABCD, 32'h0);
        run_op("alu_after", 1, 0, 0, 32'hABCD, 32'h0, 5'd9, 0, 32'h0, 0);
        run_op("alu_nowr", 0, 0, 0, 32'h4444, 32'h0, 5'd2, 0, 32'h0, 0);

        // Misaligned store
        push_ev(EV_ALIGN);
        run_op("misaligned_st", 0, 0, 1, 32'h201, 32'h99, 5'd0, 0, 32'h0, 0);

        // Reset in the 2nd BUSY cycle, then a late ack
        push_req(32'h300, 0, 32'h0, 0);
        mem_wreg = 1; mem_m2reg = 1; mem_wmem = 0; mem_alu = 32'h300; mem_b = 32'h0; mem_rn = 5'd6;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("busy_before_reset", {62'b0, dmem_req, stall}, 64'h3);
        clrn = 1'b0;
        #1;
        check("reset_busy_req_stall", {62'b0, dmem_req, stall}, 64'h0);
        check("reset_busy_wb", {wb_wreg, wb_m2reg, wb_rn, wb_alu, wb_mdo[24:0]}, 64'h0);
        mem_wreg = 0; mem_m2reg = 0; mem_alu = '0; mem_rn = '0;
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_0000;
        @(posedge clk); #3 clrn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_ack_ignored", {60'b0, dmem_req, stall, wb_wreg, bus_err}, 64'h0);
        end
        @(posedge clk); #1 dmem_ack = 1'b0;

        push_wb(1, 0, 5'd11, 32'h5678, 32'h0);
        run_op("alu_post_reset", 1, 0, 0, 32'h5678, 32'h0, 5'd11, 0, 32'h0, 0);

        mem_wreg = 0; mem_m2reg = 0; mem_wmem = 0; mem_alu = '0;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending events required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit reached required completion");
        $fatal(1);
    end

endmodule
